// File: rtl/cnt_sched_pkg.sv
// cnt_sched_pkg: shared FSM state type, default sizes and the round-robin
// search helper used by the cnt_sched arbiter.
package cnt_sched_pkg;

    localparam int CNT_SCHED_NREQ   = 4;
    localparam int CNT_SCHED_WIDTH  = 8;
    localparam int CNT_SCHED_MAXREQ = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Index of the first set bit of req at or after ptr, wrapping modulo nreq.
    // Returns 0 when req is empty; callers qualify the result with |req.
    function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] ptr,
                                           input logic [3:0] nreq);
        logic [2:0] pick;
        logic       found;
        logic [3:0] idx;
        pick  = 3'd0;
        found = 1'b0;
        for (int k = 0; k < CNT_SCHED_MAXREQ; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= nreq) begin
                idx = idx - nreq;
            end else begin
                idx = idx;
            end
            if ((4'(k) < nreq) && !found && req[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/cnt_sched_if.sv
// cnt_sched_if: client-side bundle of the shared counter scheduler.
// master = requester side, slave = cnt_sched side.
interface cnt_sched_if
    import cnt_sched_pkg::*;
#(
    parameter int NREQ  = CNT_SCHED_NREQ,
    parameter int WIDTH = CNT_SCHED_WIDTH
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] start_val;
    logic [NREQ*WIDTH-1:0] end_val;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic [IDXW-1:0]       owner;
    logic [WIDTH-1:0]      count_out;

    modport master (
        output req, start_val, end_val,
        input  gnt, done, busy, owner, count_out
    );

    modport slave (
        input  req, start_val, end_val,
        output gnt, done, busy, owner, count_out
    );
endinterface

// File: rtl/cnt_sched_rr_arb.sv
// cnt_sched_rr_arb: combinational arbiter, pending requests + pointer ->
// one-hot winner and its index.
// Build option CNT_SCHED_FIXED_PRIO_EN: fixed priority (lowest index wins),
// the pointer input is removed. Default: round-robin from the pointer.
module cnt_sched_rr_arb
    import cnt_sched_pkg::*;
#(
    parameter int NREQ = CNT_SCHED_NREQ,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
`ifndef CNT_SCHED_FIXED_PRIO_EN
    input  logic [IDXW-1:0] ptr,
`endif
    output logic            win_vld,
    output logic [IDXW-1:0] win_idx,
    output logic [NREQ-1:0] win_oh
);
    logic [7:0] req_pad_s;
    logic [2:0] ptr_pad_s;
    logic [2:0] pick_s;

    // Zero-extend request vector and pointer to the helper's 8-requester width.
    always_comb begin
        req_pad_s           = 8'd0;
        req_pad_s[NREQ-1:0] = req;
        ptr_pad_s           = 3'd0;
`ifndef CNT_SCHED_FIXED_PRIO_EN
        ptr_pad_s[IDXW-1:0] = ptr;
`endif
    end

    // Pick the winner; fixed priority is a search that always starts at 0.
    always_comb begin
        pick_s  = rr_pick(req_pad_s, ptr_pad_s, 4'(NREQ));
        win_vld = |req;
        win_idx = pick_s[IDXW-1:0];
        win_oh  = {NREQ{1'b0}};
        if (win_vld) begin
            win_oh[win_idx] = 1'b1;
        end else begin
            win_oh = {NREQ{1'b0}};
        end
    end
endmodule

// File: rtl/cnt_sched.sv
// cnt_sched: one WIDTH-bit up-counter shared by NREQ requesters. The arbiter
// picks an owner, the FSM loads start, counts to end (mod 2**WIDTH), pulses
// done to the owner and releases. Dropping req[owner] before DONE aborts.
// Build option CNT_SCHED_FIXED_PRIO_EN: fixed-priority arbitration, no rr pointer.
module cnt_sched
    import cnt_sched_pkg::*;
#(
    parameter int NREQ  = CNT_SCHED_NREQ,
    parameter int WIDTH = CNT_SCHED_WIDTH
) (
    input  logic       clk,
    input  logic       reset,
    cnt_sched_if.slave bus
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e           state_r, state_nxt_s;
    logic [NREQ-1:0]  gnt_r, gnt_nxt_s;
    logic [NREQ-1:0]  done_r, done_nxt_s;
    logic             busy_r;
    logic [IDXW-1:0]  owner_r, owner_nxt_s;
    logic [WIDTH-1:0] count_r, count_nxt_s;
    logic [WIDTH-1:0] start_lat_r, start_lat_nxt_s;
    logic [WIDTH-1:0] end_lat_r, end_lat_nxt_s;
    logic             arb_vld_s;
    logic [IDXW-1:0]  arb_idx_s;
    logic [NREQ-1:0]  arb_oh_s;
    logic             req_own_s;
`ifndef CNT_SCHED_FIXED_PRIO_EN
    logic [IDXW-1:0]  ptr_r, ptr_adv_s;
`endif

    cnt_sched_rr_arb #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
        .req     (bus.req),
`ifndef CNT_SCHED_FIXED_PRIO_EN
        .ptr     (ptr_r),
`endif
        .win_vld (arb_vld_s),
        .win_idx (arb_idx_s),
        .win_oh  (arb_oh_s)
    );

    assign req_own_s = bus.req[owner_r];

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: an owner dropping its request before DONE aborts the session.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_vld_s) state_nxt_s = ST_LOAD;
                else           state_nxt_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (!req_own_s) state_nxt_s = ST_IDLE;
                else            state_nxt_s = ST_COUNT;
            end
            ST_COUNT: begin
                if (!req_own_s)                  state_nxt_s = ST_IDLE;
                else if (count_r == end_lat_r)   state_nxt_s = ST_DONE;
                else                             state_nxt_s = ST_COUNT;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: next values of grant, done, owner, counter and latched bounds.
    always_comb begin
        gnt_nxt_s       = gnt_r;
        done_nxt_s      = {NREQ{1'b0}};
        owner_nxt_s     = owner_r;
        count_nxt_s     = count_r;
        start_lat_nxt_s = start_lat_r;
        end_lat_nxt_s   = end_lat_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_vld_s) begin
                    gnt_nxt_s       = arb_oh_s;
                    owner_nxt_s     = arb_idx_s;
                    start_lat_nxt_s = bus.start_val[arb_idx_s*WIDTH +: WIDTH];
                    end_lat_nxt_s   = bus.end_val[arb_idx_s*WIDTH +: WIDTH];
                end else begin
                    gnt_nxt_s       = {NREQ{1'b0}};
                end
            end
            ST_LOAD: begin
                if (!req_own_s) gnt_nxt_s   = {NREQ{1'b0}};
                else            count_nxt_s = start_lat_r;
            end
            ST_COUNT: begin
                if (!req_own_s)                gnt_nxt_s   = {NREQ{1'b0}};
                else if (count_r == end_lat_r) done_nxt_s  = gnt_r;
                else                           count_nxt_s = count_r + WIDTH'(1);
            end
            ST_DONE: gnt_nxt_s = {NREQ{1'b0}};
            default: gnt_nxt_s = {NREQ{1'b0}};
        endcase
    end

    // Registered outputs and datapath; the counter holds across aborts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_r       <= {NREQ{1'b0}};
            done_r      <= {NREQ{1'b0}};
            busy_r      <= 1'b0;
            owner_r     <= {IDXW{1'b0}};
            count_r     <= {WIDTH{1'b0}};
            start_lat_r <= {WIDTH{1'b0}};
            end_lat_r   <= {WIDTH{1'b0}};
        end else begin
            gnt_r       <= gnt_nxt_s;
            done_r      <= done_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            owner_r     <= owner_nxt_s;
            count_r     <= count_nxt_s;
            start_lat_r <= start_lat_nxt_s;
            end_lat_r   <= end_lat_nxt_s;
        end
    end

`ifndef CNT_SCHED_FIXED_PRIO_EN
    // Pointer successor of the current owner, wrapping at NREQ.
    always_comb begin
        if (owner_r == IDXW'(NREQ - 1)) ptr_adv_s = {IDXW{1'b0}};
        else                            ptr_adv_s = owner_r + IDXW'(1);
    end

    // Round-robin pointer moves past the owner whenever a session ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= {IDXW{1'b0}};
        end else if ((state_r != ST_IDLE) && (state_nxt_s == ST_IDLE)) begin
            ptr_r <= ptr_adv_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`endif

    assign bus.gnt       = gnt_r;
    assign bus.done      = done_r;
    assign bus.busy      = busy_r;
    assign bus.owner     = owner_r;
    assign bus.count_out = count_r;
endmodule

// File: tb/tb_cnt_sched.sv
// tb_cnt_sched: session-level reference model checked every cycle, a table of
// single-requester sessions, hand sequences for ordering/abort/reset and a
// randomized request phase.
module tb_cnt_sched;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cnt_sched_if #(.NREQ(4), .WIDTH(8)) bus ();
    cnt_sched #(.NREQ(4), .WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: session described by owner, bounds and cycles since grant.
    bit         m_act;
    int         m_own, m_t, m_ptr;
    logic [7:0] m_s, m_e, m_cnt;

    typedef struct {
        int         idx;
        logic [7:0] s;
        logic [7:0] e;
        int         exp_len;
        logic [7:0] exp_cnt;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_own = 0; m_t = 0; m_ptr = 0;
        m_s = 8'd0; m_e = 8'd0; m_cnt = 8'd0;
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_edge();
        logic [7:0] d;
        int n, k, base;
        bit found;
        if (reset !== 1'b1) begin
            model_reset();
            return;
        end
        if (!m_act) begin
            if (bus.req != 4'd0) begin
                base = m_ptr;
`ifdef CNT_SCHED_FIXED_PRIO_EN
                base = 0;
`endif
                found = 0;
                for (int j = 0; j < 4; j++) begin
                    k = (base + j) % 4;
                    if (!found && bus.req[k]) begin
                        m_own = k;
                        found = 1;
                    end
                end
                m_s = bus.start_val[m_own*8 +: 8];
                m_e = bus.end_val[m_own*8 +: 8];
                m_t = 0;
                m_act = 1;
            end
        end else begin
            d = m_e - m_s;
            n = int'(d);
            if (m_t <= n + 1 && !bus.req[m_own]) begin
                m_act = 0;
                m_ptr = (m_own + 1) % 4;
            end else if (m_t == n + 2) begin
                m_act = 0;
                m_ptr = (m_own + 1) % 4;
            end else begin
                m_t++;
                k = m_t - 1;
                if (k > n) k = n;
                m_cnt = m_s + 8'(k);
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] eg, ed;
        logic [7:0] d;
        eg = 4'd0;
        ed = 4'd0;
        if (m_act) begin
            eg[m_own] = 1'b1;
            d = m_e - m_s;
            if (m_t == int'(d) + 2) ed[m_own] = 1'b1;
        end
        check("gnt",   32'(bus.gnt),       32'(eg));
        check("done",  32'(bus.done),      32'(ed));
        check("busy",  32'(bus.busy),      32'(m_act));
        check("owner", 32'(bus.owner),     32'(m_own));
        check("count", 32'(bus.count_out), 32'(m_cnt));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_vals(input int idx, input logic [7:0] s, input logic [7:0] e);
        bus.start_val[idx*8 +: 8] = s;
        bus.end_val[idx*8 +: 8]   = e;
    endtask

    task automatic check_zero(input string name);
        check({name, "_gnt"},   32'(bus.gnt),       32'd0);
        check({name, "_done"},  32'(bus.done),      32'd0);
        check({name, "_busy"},  32'(bus.busy),      32'd0);
        check({name, "_count"}, 32'(bus.count_out), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_zero("rst");
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic wait_idle();
        int cyc;
        bus.req = 4'd0;
        cyc = 0;
        while (bus.busy && cyc < 20) begin
            step();
            cyc++;
        end
        check("idle_timeout", 32'(cyc < 20), 32'd1);
    endtask

    task automatic run_session(input int idx, input logic [7:0] s, input logic [7:0] e,
                               input int exp_len, input logic [7:0] exp_cnt);
        int len, dn, lat, cyc;
        bit seen;
        logic [3:0] dmask;
        set_vals(idx, s, e);
        bus.req = 4'd1 << idx;
        len = 0; dn = 0; lat = 0; cyc = 0; seen = 0; dmask = 4'd0;
        while (cyc < 400) begin
            step();
            cyc++;
            if (bus.gnt != 4'd0) begin
                if (!seen) lat = cyc;
                seen = 1;
                len++;
            end
            if (bus.done != 4'd0) begin
                dn++;
                dmask = bus.done;
                bus.req = 4'd0;
            end
            if (seen && bus.gnt == 4'd0) break;
        end
        check("sess_timeout", 32'(cyc < 400),   32'd1);
        check("sess_latency", 32'(lat),         32'd1);
        check("sess_len",     32'(len),         32'(exp_len));
        check("sess_ndone",   32'(dn),          32'd1);
        check("sess_donebit", 32'(dmask),       32'(4'd1 << idx));
        check("sess_owner",   32'(bus.owner),   32'(idx));
        check("sess_final",   32'(bus.count_out), 32'(exp_cnt));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, ng, dn;
        bit prev;
        int got[5];
        int exp_order[5];
        logic [7:0] rs;

        reset = 1'b0;
        bus.req = 4'd0;
        bus.start_val = 32'd0;
        bus.end_val = 32'd0;
        model_reset();
        repeat (3) step();
        reset = 1'b1;

        // Idle after reset: everything stays zero.
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_busy", 32'(bus.busy), 32'd0);
        end

        // Table of single-requester sessions.
        tbl[0] = '{0, 8'd3,   8'd5,   5,   8'd5};
        tbl[1] = '{2, 8'hFE,  8'h01,  6,   8'h01};
        tbl[2] = '{1, 8'd7,   8'd7,   3,   8'd7};
        tbl[3] = '{3, 8'd0,   8'hFF,  258, 8'hFF};
        tbl[4] = '{0, 8'd10,  8'd9,   258, 8'd9};
        tbl[5] = '{1, 8'h80,  8'h84,  7,   8'h84};
        for (int i = 0; i < 6; i++) begin
            wait_idle();
            run_session(tbl[i].idx, tbl[i].s, tbl[i].e, tbl[i].exp_len, tbl[i].exp_cnt);
        end

        // Grant order with all requesters pending, from a fresh pointer.
        wait_idle();
        do_reset();
        for (int i = 0; i < 4; i++) set_vals(i, 8'd0, 8'd0);
`ifdef CNT_SCHED_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        bus.req = 4'hF;
        ng = 0; cyc = 0; prev = 0;
        while (ng < 5 && cyc < 200) begin
            step();
            cyc++;
            if (bus.gnt != 4'd0 && !prev) begin
                got[ng] = int'(bus.owner);
                ng++;
            end
            prev = (bus.gnt != 4'd0);
        end
        check("order_timeout", 32'(ng), 32'd5);
        for (int i = 0; i < 5; i++) check("order", 32'(got[i]), 32'(exp_order[i]));
        wait_idle();

        // Abort: drop req[1] when the count reaches 50.
        set_vals(1, 8'd0, 8'd200);
        bus.req = 4'b0010;
        cyc = 0;
        while (!(bus.busy && bus.count_out == 8'd50) && cyc < 300) begin
            step();
            cyc++;
        end
        check("abort_reach", 32'(cyc < 300), 32'd1);
        bus.req = 4'd0;
        dn = 0;
        step();
        check("abort_busy",  32'(bus.busy),      32'd0);
        check("abort_gnt",   32'(bus.gnt),       32'd0);
        check("abort_count", 32'(bus.count_out), 32'd50);
        if (bus.done != 4'd0) dn++;
        repeat (3) begin
            step();
            if (bus.done != 4'd0) dn++;
        end
        check("abort_nodone", 32'(dn), 32'd0);
        check("abort_hold",   32'(bus.count_out), 32'd50);

        // Reset in the middle of a session, then a normal session.
        set_vals(2, 8'd0, 8'd200);
        bus.req = 4'b0100;
        cyc = 0;
        while (!(bus.busy && bus.count_out == 8'd100) && cyc < 300) begin
            step();
            cyc++;
        end
        check("midrst_reach", 32'(cyc < 300), 32'd1);
        bus.req = 4'd0;
        do_reset();
        run_session(2, 8'd20, 8'd24, 7, 8'd24);

        // Randomized requests and bounds, compared against the model every cycle.
        wait_idle();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) bus.req[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 5) == 0) begin
                rs = 8'($urandom);
                set_vals(int'($urandom_range(0, 3)), rs, rs + 8'($urandom_range(0, 6)));
            end
            step();
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
